// File: rtl/edge_filter_sequencer.sv
// edge_filter_sequencer: fetches 3x3 RGB windows, waits out the filter latency and writes each result.
// Optional EDGE_SEQ_BORDER_ZERO_EN: full-frame raster, border pixels written as zero without fetching.
module edge_filter_sequencer #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int ADDR_W = 16,
    parameter logic [ADDR_W-1:0] RD_BASE = '0,
    parameter logic [ADDR_W-1:0] WR_BASE = ADDR_W'(16'h8000),
    parameter int FILTER_LAT = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [23:0]       rd_data,
    output logic [71:0]       red_win,
    output logic [71:0]       green_win,
    output logic [71:0]       blue_win,
    input  logic [23:0]       pixel_data,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    input  logic              wr_ack
);
    localparam int CW = $clog2(IMG_W > IMG_H ? IMG_W : IMG_H) + 1;
    localparam int LW = $clog2(FILTER_LAT + 1);
`ifdef EDGE_SEQ_BORDER_ZERO_EN
    localparam int LO = 0;
    localparam int HI_X = IMG_W - 1;
    localparam int HI_Y = IMG_H - 1;
`else
    localparam int LO = 1;
    localparam int HI_X = IMG_W - 2;
    localparam int HI_Y = IMG_H - 2;
`endif

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_WRITE, S_NEXT, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [CW-1:0]     r_x, r_y, w_tx, w_ty, w_ax, w_ay;
    logic [3:0]        r_k;
    logic [1:0]        w_kr, w_kc;
    logic [LW-1:0]     r_cnt;
    logic              r_rd_req;
    logic [ADDR_W-1:0] r_rd_addr, r_wr_addr, w_rd_addr, w_wr_addr;
    logic [23:0]       r_wr_data;
    logic [71:0]       r_red, r_grn, r_blu;
    logic              w_last, w_tb, w_load, w_rd_hit, w_lat_hit;

    assign w_rd_hit  = (r_state == S_FETCH) && r_rd_req && rd_ack;
    assign w_lat_hit = (r_cnt == LW'(FILTER_LAT));
    assign w_load    = (r_state == S_IDLE && start) || (r_state == S_NEXT && !w_last);

    // Target of the next raster step; from IDLE it is the first pixel of the frame.
    always_comb begin
        w_last = 1'b0;
        w_tx = CW'(LO);
        w_ty = CW'(LO);
        if (r_state == S_NEXT) begin
            if (r_x < CW'(HI_X)) begin
                w_tx = r_x + CW'(1);
                w_ty = r_y;
            end else if (r_y < CW'(HI_Y)) begin
                w_ty = r_y + CW'(1);
            end else begin
                w_last = 1'b1;
            end
        end
    end

`ifdef EDGE_SEQ_BORDER_ZERO_EN
    assign w_tb = (w_tx == '0) || (w_ty == '0) || (w_tx == CW'(IMG_W - 1)) || (w_ty == CW'(IMG_H - 1));
`else
    assign w_tb = 1'b0;
`endif

    assign w_kr = (r_k >= 4'd6) ? 2'd2 : (r_k >= 4'd3) ? 2'd1 : 2'd0;
    assign w_kc = 2'(r_k - {2'b00, w_kr} * 4'd3);
    assign w_rd_addr = RD_BASE + (ADDR_W'(r_y) + ADDR_W'(w_kr) - ADDR_W'(1)) * ADDR_W'(IMG_W)
                     + ADDR_W'(r_x) + ADDR_W'(w_kc) - ADDR_W'(1);
    assign w_ax = (r_state == S_WAIT) ? r_x : w_tx;
    assign w_ay = (r_state == S_WAIT) ? r_y : w_ty;
    assign w_wr_addr = WR_BASE + ADDR_W'(w_ay) * ADDR_W'(IMG_W) + ADDR_W'(w_ax);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = w_tb ? S_WRITE : S_FETCH;
            S_FETCH: if (w_rd_hit && r_k == 4'd8) w_next = S_WAIT;
            S_WAIT:  if (w_lat_hit) w_next = S_WRITE;
            S_WRITE: if (wr_ack) w_next = S_NEXT;
            S_NEXT:  w_next = w_last ? S_DONE : w_tb ? S_WRITE : S_FETCH;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_WRITE) || (r_state == S_NEXT);
        done   = (r_state == S_DONE);
        wr_req = (r_state == S_WRITE);
    end

    // rd_req is re-raised only from a low cycle, which guarantees the gap between reads.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_x       <= '0;
            r_y       <= '0;
            r_k       <= '0;
            r_cnt     <= '0;
            r_rd_req  <= 1'b0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_red     <= '0;
            r_grn     <= '0;
            r_blu     <= '0;
        end else begin
            if (w_load) begin
                r_x <= w_tx;
                r_y <= w_ty;
                r_k <= '0;
            end
            if (w_load && w_tb) begin
                r_wr_addr <= w_wr_addr;
                r_wr_data <= '0;
            end
            if (r_state == S_FETCH) begin
                if (w_rd_hit) begin
                    r_rd_req <= 1'b0;
                    r_k      <= r_k + 4'd1;
                    r_red[{r_k, 3'b000} +: 8] <= rd_data[23:16];
                    r_grn[{r_k, 3'b000} +: 8] <= rd_data[15:8];
                    r_blu[{r_k, 3'b000} +: 8] <= rd_data[7:0];
                end else if (!r_rd_req) begin
                    r_rd_req  <= 1'b1;
                    r_rd_addr <= w_rd_addr;
                end
            end
            if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + LW'(1);
                if (w_lat_hit) begin
                    r_wr_data <= pixel_data;
                    r_wr_addr <= w_wr_addr;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign rd_req    = r_rd_req;
    assign rd_addr   = r_rd_addr;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign red_win   = r_red;
    assign green_win = r_grn;
    assign blue_win  = r_blu;
endmodule

// File: tb/tb_edge_filter_sequencer.sv
// tb_edge_filter_sequencer: randomized scoreboard bench for edge_filter_sequencer on a 4x4 frame.
module tb_edge_filter_sequencer;
    localparam int W = 4;
    localparam int H = 4;
    localparam int LAT = 2;
    localparam logic [15:0] WB = 16'h8000;
`ifdef EDGE_SEQ_BORDER_ZERO_EN
    localparam int B = 0;
`else
    localparam int B = 1;
`endif
    localparam int NRD = (W - 2) * (H - 2) * 9;
    localparam int NWR = (W - 2 * B) * (H - 2 * B);

    typedef struct {
        logic [15:0] a;
        logic [23:0] d;
        logic        chk;
        logic [71:0] rw;
    } wr_t;

    logic clk = 1'b0, n_rst, start, rd_ack, wr_ack;
    logic busy, done, rd_req, wr_req;
    logic [15:0] rd_addr, wr_addr;
    logic [23:0] rd_data, pixel_data, wr_data, p1, p2;
    logic [71:0] red_win, green_win, blue_win;
    logic [23:0] mem [0:W*H-1];

    logic [15:0] exp_rd[$];
    wr_t exp_wr[$];
    int tests = 0, fails = 0, n_rd = 0, n_wr = 0, n_done = 0;
    int rd_max = 0, wr_max = 0, rd_dly = 0, wr_dly = 0;
    bit spur = 0, rd_pend = 0, wr_pend = 0;
    logic pr_rd_req = 0, pr_rd_ack = 0, pr_wr_req = 0, pr_wr_ack = 0;
    logic [15:0] pr_rd_addr = 0, pr_wr_addr = 0;
    logic [23:0] pr_wr_data = 0;

    edge_filter_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(16), .RD_BASE(16'h0000),
                            .WR_BASE(WB), .FILTER_LAT(LAT)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .busy(busy), .done(done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .red_win(red_win), .green_win(green_win), .blue_win(blue_win),
        .pixel_data(pixel_data), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ack(wr_ack));

    always #5 clk = ~clk;

    // Stand-in filter: position-sensitive mix of the window, delayed by LAT registers.
    function automatic logic [23:0] filt(input logic [71:0] r, input logic [71:0] g, input logic [71:0] b);
        logic [7:0] a, c, d;
        a = 8'h00;
        c = 8'h00;
        for (int k = 0; k < 9; k++) begin
            a = a + r[8*k +: 8] * 8'(k + 1);
            c = {c[6:0], c[7]} ^ g[8*k +: 8];
        end
        d = b[39:32] - b[7:0] + b[71:64];
        return {a, c, d};
    endfunction

    always @(posedge clk) begin
        p1 <= filt(red_win, green_win, blue_win);
        p2 <= p1;
    end
    assign pixel_data = p2;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: raster of windows built straight from the frame contents.
    task automatic load_model();
        wr_t e;
        logic [71:0] r, g, b;
        int p;
        exp_rd.delete();
        exp_wr.delete();
        for (int y = B; y <= H - 1 - B; y++) begin
            for (int x = B; x <= W - 1 - B; x++) begin
                e.a = WB + 16'(y * W + x);
                if (x == 0 || y == 0 || x == W - 1 || y == H - 1) begin
                    e.d = 24'h0;
                    e.chk = 1'b0;
                    e.rw = 72'h0;
                end else begin
                    for (int k = 0; k < 9; k++) begin
                        p = (y - 1 + k / 3) * W + (x - 1 + k % 3);
                        exp_rd.push_back(16'(p));
                        r[8*k +: 8] = mem[p][23:16];
                        g[8*k +: 8] = mem[p][15:8];
                        b[8*k +: 8] = mem[p][7:0];
                    end
                    e.d = filt(r, g, b);
                    e.chk = 1'b1;
                    e.rw = r;
                end
                exp_wr.push_back(e);
            end
        end
    endtask

    // Memory and frame-buffer responders with random ack delays and optional stray acks.
    always @(negedge clk) begin
        rd_ack = 1'b0;
        wr_ack = 1'b0;
        if (!n_rst) begin
            rd_pend = 0;
            wr_pend = 0;
        end else begin
            if (rd_req) begin
                if (!rd_pend) begin
                    rd_pend = 1;
                    rd_dly = $urandom_range(0, rd_max);
                end
                if (rd_dly == 0) begin
                    rd_ack = 1'b1;
                    rd_data = mem[rd_addr[3:0]];
                    rd_pend = 0;
                end else rd_dly--;
            end else if (spur && $urandom_range(0, 3) == 0) begin
                rd_ack = 1'b1;
                rd_data = 24'($urandom);
            end
            if (wr_req) begin
                if (!wr_pend) begin
                    wr_pend = 1;
                    wr_dly = $urandom_range(0, wr_max);
                end
                if (wr_dly == 0) begin
                    wr_ack = 1'b1;
                    wr_pend = 0;
                end else wr_dly--;
            end else if (spur && $urandom_range(0, 3) == 0) wr_ack = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every accepted transfer and checks request stability.
    always @(negedge clk) begin
        wr_t e;
        #2;
        if (n_rst) begin
            if (rd_req && pr_rd_req && !pr_rd_ack) chk("rd_addr_stable", rd_addr, pr_rd_addr);
            if (wr_req && pr_wr_req && !pr_wr_ack) begin
                chk("wr_addr_stable", wr_addr, pr_wr_addr);
                chk("wr_data_stable", wr_data, pr_wr_data);
            end
            if (rd_req && rd_ack) begin
                n_rd++;
                if (exp_rd.size() == 0) chk("rd_unexpected", rd_addr, 72'hFFFF_FFFF);
                else chk("rd_addr", rd_addr, exp_rd.pop_front());
            end
            if (wr_req && wr_ack) begin
                n_wr++;
                if (exp_wr.size() == 0) chk("wr_unexpected", wr_addr, 72'hFFFF_FFFF);
                else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", wr_addr, e.a);
                    chk("wr_data", wr_data, e.d);
                    if (e.chk) chk("red_win", red_win, e.rw);
                end
            end
            if (done) n_done++;
        end
        pr_rd_req = n_rst && rd_req;
        pr_rd_ack = rd_ack;
        pr_rd_addr = rd_addr;
        pr_wr_req = n_rst && wr_req;
        pr_wr_ack = wr_ack;
        pr_wr_addr = wr_addr;
        pr_wr_data = wr_data;
    end

    task automatic run_frame(input bit spam);
        int r0, w0, d0, c;
        r0 = n_rd;
        w0 = n_wr;
        d0 = n_done;
        load_model();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #3 chk("busy_after_start", busy, 1);
        c = 0;
        while (n_done == d0 && c < 4000) begin
            @(negedge clk);
            start = spam && busy && (c % 37 == 5);
            #3 c++;
        end
        start = 1'b0;
        chk("frame_done", n_done - d0, 1);
        repeat (40) @(negedge clk);
        #3;
        chk("done_once", n_done - d0, 1);
        chk("read_count", n_rd - r0, NRD);
        chk("write_count", n_wr - w0, NWR);
        chk("rd_queue_empty", exp_rd.size(), 0);
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("idle_not_busy", busy, 0);
    endtask

    initial begin
        int r0, d0, c;
        logic [71:0] e0a;
        n_rst = 1'b0;
        start = 1'b0;
        rd_ack = 1'b0;
        wr_ack = 1'b0;
        rd_data = 24'h0;
        repeat (2) @(negedge clk);
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_red_win", red_win, 0);
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < W * H; i++) mem[i] = 24'h0A0A0A;
        run_frame(0);
        e0a = {9{8'h0A}};
        chk("const_red_win", red_win, e0a);
        chk("const_green_win", green_win, e0a);

        for (int i = 0; i < W * H; i++) mem[i] = {3{8'(i)}};
        run_frame(0);

        for (int i = 0; i < W * H; i++) mem[i] = 24'($urandom);
        rd_max = 3;
        wr_max = 5;
        spur = 1;
        run_frame(1);
        rd_max = 0;
        wr_max = 0;
        spur = 0;

        load_model();
        r0 = n_rd;
        d0 = n_done;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!(rd_req && rd_ack && n_rd - r0 == 5) && c < 500) begin
            @(negedge clk);
            #3 c++;
        end
        chk("reach_k4", n_rd - r0, 5);
        n_rst = 1'b0;
        #1;
        chk("midrst_rd_req", rd_req, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_addr", rd_addr, 0);
        repeat (3) @(negedge clk);
        chk("midrst_no_done", n_done - d0, 0);
        n_rst = 1'b1;
        for (int i = 0; i < W * H; i++) mem[i] = 24'($urandom);
        run_frame(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
